// File: rtl/adc_conv_sequencer.sv
// Conversion/readout sequencer for the AD4003 array: CNVST pulse, SCK gate,
// deserializer shift enable and a data_valid strobe, free-running at a latched period.
module adc_conv_sequencer #(
    parameter int unsigned ADC_DATA_WIDTH = 18,
    parameter int unsigned CONV_CYCLES    = 26,
    parameter int unsigned READ_DELAY     = 2
) (
    input  logic        adc_spi_clk,
    input  logic        rst,
    input  logic        acq_en,
    input  logic [15:0] sample_period,
    output logic        cnvst,
    output logic        sck_en,
    output logic        reader_en_sync,
    output logic        data_valid,
    output logic        busy,
    output logic [31:0] sample_cnt,
    output logic        period_clamped
);

    localparam int unsigned MIN_PERIOD = CONV_CYCLES + ADC_DATA_WIDTH + READ_DELAY + 1;
    localparam logic [15:0] MIN_P      = 16'(MIN_PERIOD);
    localparam logic [15:0] CONV_LAST  = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] READ_LAST  = 16'(CONV_CYCLES + ADC_DATA_WIDTH - 1);
    localparam logic [15:0] DELAY_LAST = 16'(MIN_PERIOD - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_READ,
        S_DELAY,
        S_VALID,
        S_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] fc_q, fc_d;
    logic [15:0] per_q, per_d;
    logic [31:0] sample_cnt_q, sample_cnt_d;
    logic        clamped_q, clamped_d;
    logic        cnvst_q, cnvst_d;
    logic        sck_en_q, sck_en_d;
    logic        data_valid_q, data_valid_d;
    logic        busy_q, busy_d;
    logic        frame_start;
    logic        frame_last;
    logic        clamp_now;

    always_ff @(posedge adc_spi_clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fc_q         <= '0;
            per_q        <= MIN_P;
            sample_cnt_q <= '0;
            clamped_q    <= 1'b0;
            cnvst_q      <= 1'b0;
            sck_en_q     <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fc_q         <= fc_d;
            per_q        <= per_d;
            sample_cnt_q <= sample_cnt_d;
            clamped_q    <= clamped_d;
            cnvst_q      <= cnvst_d;
            sck_en_q     <= sck_en_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Phase boundaries are taken from the frame counter, which restarts at each frame start.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_last  = (fc_q == per_q - 16'd1);
        unique case (state_q)
            S_IDLE: begin
                if (acq_en) begin
                    state_d     = S_CONV;
                    frame_start = 1'b1;
                end
            end
            S_CONV: begin
                if (fc_q == CONV_LAST) state_d = S_READ;
            end
            S_READ: begin
                if (fc_q == READ_LAST) state_d = (READ_DELAY == 0) ? S_VALID : S_DELAY;
            end
            S_DELAY: begin
                if (fc_q == DELAY_LAST) state_d = S_VALID;
            end
            S_VALID, S_WAIT: begin
                if (frame_last) begin
                    if (acq_en) begin
                        state_d     = S_CONV;
                        frame_start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnvst_d      = (state_d == S_CONV);
        sck_en_d     = (state_d == S_READ);
        data_valid_d = (state_d == S_VALID);
        busy_d       = (state_d != S_IDLE);

        clamp_now    = (sample_period < MIN_P);
        per_d        = per_q;
        clamped_d    = clamped_q;
        if (frame_start) begin
            per_d     = clamp_now ? MIN_P : sample_period;
            clamped_d = clamped_q | clamp_now;
        end

        if (frame_start)            fc_d = '0;
        else if (state_q != S_IDLE) fc_d = fc_q + 16'd1;
        else                        fc_d = fc_q;

        sample_cnt_d = (state_d == S_VALID) ? sample_cnt_q + 32'd1 : sample_cnt_q;
    end

    assign cnvst          = cnvst_q;
    assign sck_en         = sck_en_q;
    assign reader_en_sync = sck_en_q;
    assign data_valid     = data_valid_q;
    assign busy           = busy_q;
    assign sample_cnt     = sample_cnt_q;
    assign period_clamped = clamped_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: expected edge events are queued per frame and
// matched against edges observed on the DUT outputs.
module tb_adc_conv_sequencer;

    localparam int K_CNV_RISE = 0;
    localparam int K_CNV_FALL = 1;
    localparam int K_SCK_RISE = 2;
    localparam int K_SCK_FALL = 3;
    localparam int K_DV       = 4;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acq_en = 1'b0;
    logic [15:0] sample_period = 16'd80;
    logic        cnvst, sck_en, reader_en_sync, data_valid, busy, period_clamped;
    logic [31:0] sample_cnt;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  ovl_err = 0;
    bit  mon_en = 1'b0;
    logic pc = 1'b0, ps = 1'b0;
    ev_t exp_q[$];

    adc_conv_sequencer #(
        .ADC_DATA_WIDTH(18),
        .CONV_CYCLES   (26),
        .READ_DELAY    (2)
    ) dut (
        .adc_spi_clk   (clk),
        .rst           (rst),
        .acq_en        (acq_en),
        .sample_period (sample_period),
        .cnvst         (cnvst),
        .sck_en        (sck_en),
        .reader_en_sync(reader_en_sync),
        .data_valid    (data_valid),
        .busy          (busy),
        .sample_cnt    (sample_cnt),
        .period_clamped(period_clamped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each observed edge pops the oldest expected event and is compared.
    always @(negedge clk) begin
        int kinds[$];
        ev_t e;
        kinds = {};
        if (mon_en) begin
            if (cnvst === 1'b1 && pc === 1'b0) kinds.push_back(K_CNV_RISE);
            if (cnvst === 1'b0 && pc === 1'b1) kinds.push_back(K_CNV_FALL);
            if (sck_en === 1'b1 && ps === 1'b0) kinds.push_back(K_SCK_RISE);
            if (sck_en === 1'b0 && ps === 1'b1) kinds.push_back(K_SCK_FALL);
            if (data_valid === 1'b1) kinds.push_back(K_DV);
            if (cnvst === 1'b1 && sck_en === 1'b1) ovl_err++;
            if (reader_en_sync !== sck_en) ovl_err++;
            foreach (kinds[i]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL event: got unexpected kind %0d at cycle %0d, required none", kinds[i], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind !== kinds[i] || e.cyc !== cyc)
                        $display("FAIL event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                 kinds[i], cyc, e.kind, e.cyc);
                    else n_pass++;
                end
            end
        end
        pc = cnvst;
        ps = sck_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input int t0);
        exp_q.push_back('{K_CNV_RISE, t0});
        exp_q.push_back('{K_CNV_FALL, t0 + 26});
        exp_q.push_back('{K_SCK_RISE, t0 + 26});
        exp_q.push_back('{K_SCK_FALL, t0 + 44});
        exp_q.push_back('{K_DV, t0 + 46});
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        acq_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        exp_q   = {};
        ovl_err = 0;
        mon_en  = 1'b1;
    endtask

    task automatic start_acq(output int t0);
        @(negedge clk);
        acq_en = 1'b1;
        t0 = cyc + 1;
    endtask

    task automatic end_checks(input string name, input logic exp_clamped);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL %s_missing: got %0d pending events, required 0", name, exp_q.size());
        else n_pass++;
        n_checks++;
        if (ovl_err !== 0) $display("FAIL %s_overlap: got %0d violations, required 0", name, ovl_err);
        else n_pass++;
        n_checks++;
        if (period_clamped !== exp_clamped)
            $display("FAIL %s_clamped: got %b, required %b", name, period_clamped, exp_clamped);
        else n_pass++;
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        acq_en = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 7;
        if (cnvst !== 1'b0) $display("FAIL rst_cnvst: got %b, required 0", cnvst); else n_pass++;
        if (sck_en !== 1'b0) $display("FAIL rst_sck_en: got %b, required 0", sck_en); else n_pass++;
        if (reader_en_sync !== 1'b0) $display("FAIL rst_rde: got %b, required 0", reader_en_sync); else n_pass++;
        if (data_valid !== 1'b0) $display("FAIL rst_dv: got %b, required 0", data_valid); else n_pass++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
        if (period_clamped !== 1'b0) $display("FAIL rst_clamped: got %b, required 0", period_clamped); else n_pass++;
        if (sample_cnt !== 32'd0) $display("FAIL rst_cnt: got %0d, required 0", sample_cnt); else n_pass++;
        acq_en = 1'b0;
    endtask

    task automatic test_basic();
        int t0;
        do_reset();
        sample_period = 16'd80;
        start_acq(t0);
        for (int k = 0; k < 10; k++) push_frame(t0 + k * 80);
        wait_until(t0 + 1);
        n_checks++;
        if (busy !== 1'b1 || cnvst !== 1'b1) $display("FAIL basic_start: got busy %b cnvst %b, required 1 1", busy, cnvst);
        else n_pass++;
        wait_until(t0 + 9 * 80 + 47);
        n_checks++;
        if (sample_cnt !== 32'd10) $display("FAIL basic_cnt: got %0d, required 10", sample_cnt); else n_pass++;
        acq_en = 1'b0;
        wait_until(t0 + 10 * 80 + 2);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy: got %b, required 0", busy); else n_pass++;
        end_checks("basic", 1'b0);
    endtask

    task automatic test_clamp();
        int t0;
        do_reset();
        sample_period = 16'd10;
        start_acq(t0);
        for (int k = 0; k < 4; k++) push_frame(t0 + k * 47);
        wait_until(t0 + 3 * 47 + 5);
        acq_en = 1'b0;
        wait_until(t0 + 4 * 47 + 10);
        n_checks++;
        if (sample_cnt !== 32'd4) $display("FAIL clamp_cnt: got %0d, required 4", sample_cnt); else n_pass++;
        end_checks("clamp", 1'b1);
    endtask

    task automatic test_stop();
        int t0;
        do_reset();
        sample_period = 16'd80;
        start_acq(t0);
        push_frame(t0);
        wait_until(t0 + 29);
        acq_en = 1'b0;
        wait_until(t0 + 79);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL stop_busy_hold: got %b, required 1", busy); else n_pass++;
        wait_until(t0 + 80);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL stop_busy_fall: got %b, required 0", busy); else n_pass++;
        wait_until(t0 + 200);
        end_checks("stop", 1'b0);
    endtask

    task automatic test_period_change();
        int t0;
        do_reset();
        sample_period = 16'd80;
        start_acq(t0);
        push_frame(t0);
        push_frame(t0 + 80);
        push_frame(t0 + 180);
        push_frame(t0 + 280);
        wait_until(t0 + 9);
        sample_period = 16'd100;
        wait_until(t0 + 290);
        acq_en = 1'b0;
        wait_until(t0 + 400);
        end_checks("perchg", 1'b0);
    endtask

    task automatic test_reset_mid();
        int t0, t1, t2;
        do_reset();
        sample_period = 16'd80;
        start_acq(t0);
        t1 = t0 + 80;
        t2 = t1 + 36;
        push_frame(t0);
        exp_q.push_back('{K_CNV_RISE, t1});
        exp_q.push_back('{K_CNV_FALL, t1 + 26});
        exp_q.push_back('{K_SCK_RISE, t1 + 26});
        exp_q.push_back('{K_SCK_FALL, t1 + 35});
        push_frame(t2);
        wait_until(t1 + 34);
        rst = 1'b1;
        wait_until(t1 + 35);
        n_checks += 5;
        if (sck_en !== 1'b0 || reader_en_sync !== 1'b0)
            $display("FAIL rmid_sck: got %b %b, required 0 0", sck_en, reader_en_sync); else n_pass++;
        if (cnvst !== 1'b0) $display("FAIL rmid_cnvst: got %b, required 0", cnvst); else n_pass++;
        if (data_valid !== 1'b0) $display("FAIL rmid_dv: got %b, required 0", data_valid); else n_pass++;
        if (busy !== 1'b0) $display("FAIL rmid_busy: got %b, required 0", busy); else n_pass++;
        if (sample_cnt !== 32'd0) $display("FAIL rmid_cnt: got %0d, required 0", sample_cnt); else n_pass++;
        rst = 1'b0;
        wait_until(t2);
        n_checks++;
        if (cnvst !== 1'b1) $display("FAIL rmid_restart: got %b, required 1", cnvst); else n_pass++;
        wait_until(t2 + 50);
        acq_en = 1'b0;
        wait_until(t2 + 120);
        n_checks++;
        if (sample_cnt !== 32'd1) $display("FAIL rmid_cnt_after: got %0d, required 1", sample_cnt); else n_pass++;
        end_checks("rmid", 1'b0);
    endtask

    task automatic test_wrap();
        int t0;
        do_reset();
        sample_period = 16'd80;
        start_acq(t0);
        push_frame(t0);
        push_frame(t0 + 80);
        wait_until(t0 + 50);
        force dut.sample_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.sample_cnt_q;
        wait_until(t0 + 60);
        n_checks++;
        if (sample_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap_hold: got %h, required ffffffff", sample_cnt); else n_pass++;
        wait_until(t0 + 100);
        acq_en = 1'b0;
        wait_until(t0 + 126);
        n_checks++;
        if (data_valid !== 1'b1 || sample_cnt !== 32'd0)
            $display("FAIL wrap_cnt: got dv %b cnt %h, required dv 1 cnt 00000000", data_valid, sample_cnt);
        else n_pass++;
        wait_until(t0 + 200);
        end_checks("wrap", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_stop();
        test_period_change();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_conv_sequencer.md
# adc_conv_sequencer

Conversion and readout sequencer for the AD4003 ADC array on the atca-k26 carrier. Generates the shared CNVST pulse, gates the SPI clock for one 18-bit readout frame, drives `reader_en_sync` into the per-channel deserializer bank, and issues a one-cycle `data_valid` strobe once all channel words are stable. It runs free at a programmable sample period while acquisition is enabled and counts completed samples.

## Interface
- `ADC_DATA_WIDTH`, 18: bits per conversion, equal to SCK pulses per frame.
- `CONV_CYCLES`, 26: CNVST high time in clocks (≥ 320 ns conversion at 80 MHz).
- `READ_DELAY`, 2: clocks between last SCK and `data_valid`; covers the delayed read clock and deserializer output register.
- `MIN_PERIOD`, derived, not overridable: `CONV_CYCLES + ADC_DATA_WIDTH + READ_DELAY + 1` (47 with defaults).
- `adc_spi_clk`  in  1  80 MHz sequencer clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `acq_en`  in  1  run enable, level-sensitive.
- `sample_period`  in  16  frame period in clocks; latched at each frame start.
- `cnvst`  out  1  conversion start to all ADCs.
- `sck_en`  out  1  SCK gate; SCK toggles only while high.
- `reader_en_sync`  out  1  shift enable to the deserializer bank; identical to `sck_en`.
- `data_valid`  out  1  one-cycle strobe: deserializer outputs hold the new sample.
- `busy`  out  1  high in every state except IDLE.
- `sample_cnt`  out  32  completed frames since reset.
- `period_clamped`  out  1  sticky: a latched `sample_period` was below `MIN_PERIOD`.

## Operation
- States: IDLE, CONV, READ, DELAY, VALID, WAIT. All outputs registered, decoded from next state.
- IDLE: outputs low. `acq_en`=1 → CONV; frame counter `fc` cleared to 0; `sample_period` latched into `per_q`.
- Period latch: `per_q = max(sample_period, MIN_PERIOD)`; if clamped, set `period_clamped` (cleared only by `rst`).
- `fc` increments every cycle outside IDLE, reset to 0 at each frame start.
- CONV: `cnvst`=1 for exactly `CONV_CYCLES` cycles → READ.
- READ: `sck_en`=`reader_en_sync`=1 for exactly `ADC_DATA_WIDTH` cycles → DELAY.
- DELAY: `READ_DELAY` cycles, all strobes low → VALID (with `READ_DELAY`=0, READ → VALID directly).
- VALID: one cycle, `data_valid`=1; `sample_cnt` increments on the same edge (wraps 0xFFFF_FFFF → 0).
- After VALID: if `fc` = `per_q`-1 at VALID, go straight to frame start (or IDLE if `acq_en`=0); else WAIT.
- WAIT: hold until `fc` = `per_q`-1; then `acq_en`=1 → CONV with new frame start (re-latch period, `fc`=0); `acq_en`=0 → IDLE.
- `acq_en` deasserted mid-frame: current frame completes including `data_valid`; no new frame starts. Reasserted before frame end: acquisition continues seamlessly.
- `sample_period` changes mid-frame take effect at next frame start only.
- `rst` at any cycle overrides everything: state IDLE, all outputs 0, `sample_cnt`=0, `period_clamped`=0, on the next edge; no partial `data_valid`.

## Timing
- Reset values: `cnvst`, `sck_en`, `reader_en_sync`, `data_valid`, `busy`, `period_clamped` = 0; `sample_cnt` = 0.
- `acq_en` first sampled high on edge E → `cnvst`, `busy` high from cycle E+1 (frame cycle t0).
- `cnvst` high t0 .. t0+`CONV_CYCLES`-1.
- `sck_en` high t0+`CONV_CYCLES` .. t0+`CONV_CYCLES`+`ADC_DATA_WIDTH`-1.
- `data_valid` at t0+`MIN_PERIOD`-1 (t0+46 with defaults).
- Next `cnvst` rise at t0+`per_q`; gapless back-to-back when `per_q`=`MIN_PERIOD`.
- `cnvst` and `sck_en` never high in the same cycle.
- `busy` falls the cycle after the last frame cycle once stopped.

## Test plan
- Reset, `acq_en`=1, `sample_period`=80 → `cnvst` t0..t0+25, `sck_en` t0+26..t0+43 (18 cycles), `data_valid` at t0+46, next `cnvst` at t0+80; 10 frames → `sample_cnt`=10.
- `sample_period`=10 → `per_q`=47, `period_clamped`=1, frames every 47 cycles with no idle gap; `cnvst`/`sck_en` never overlap.
- `acq_en` dropped at t0+30 → frame finishes, `data_valid` at t0+46, `busy` low from t0+80, no further `cnvst`.
- `sample_period` changed 80→100 at t0+10 → next frame spaced 80, following frames spaced 100.
- `rst` pulsed at t0+35 (mid-READ) → next cycle all outputs 0, `sample_cnt`=0, no `data_valid`; with `acq_en` held, new frame `cnvst` starts the cycle after `rst` deasserts plus one.
- `sample_cnt` preloaded near 0xFFFF_FFFF (force) → wraps to 0 on next `data_valid`.
